hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage rv32i core.
- Generates the per-stage `load` and bubble-select controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Resolves memory stalls, multicycle-unit stalls, load-use hazards and taken-branch redirects.
- Tracks a redirect that arrives while an instruction fetch is still outstanding, so the stale fetch is discarded.
- Keeps saturating stall and flush performance counters.

---
 rtl/rv32i_types.sv | 37 +++
 rtl/sat_counter.sv | 32 +++
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared types and constants for the rv32i core pipeline
//                control: hazard sequencer state encoding and the zero
//                register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    // Hazard sequencer state: RUN is normal issue; SQUASH means the PC
    // already holds a redirect target while an old-PC fetch is in flight.
    localparam int HZ_STATE_W = 1;

    typedef enum logic [HZ_STATE_W-1:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } hazard_state_t;

    // x0 is hard-wired to zero, so it can never carry a load-use dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when the ID instruction consumes the register a load in EX writes.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1_used,
        input logic       rs2_used
    );
        return mem_read && (rd != REG_ZERO) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;

    // Count requested events, holding once the maximum value is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + ONE;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline sequencer for the 5-stage rv32i core. Produces the
//                stage-register load enables and bubble selects, resolves
//                memory / mul-div / load-use stalls and taken-branch
//                redirects, discards a stale fetch after a redirect, and
//                keeps saturating stall and flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             md_busy,
    input  logic             ex_br_taken,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_if_id,
    output logic             bubble_id_ex,
    output logic             bubble_ex_mem,
    output logic             squash_fetch,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazard_state_t state_q;
    hazard_state_t state_d;

    logic lu;
    logic br_accept;
    logic stall_inc;
    logic flush_inc;

    assign lu = load_use_hit(ex_mem_read, ex_rd, id_rs1, id_rs2,
                             id_rs1_used, id_rs2_used);

    // A redirect is only accepted when EX actually advances this cycle; a
    // frozen or mul/div-held EX re-presents the branch later.
    assign br_accept = ex_br_taken && !dmem_stall && !md_busy;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter SQUASH when a redirect lands on an outstanding
    // fetch; leave it the cycle that fetch finally returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (br_accept && imem_stall) state_d = SQUASH;
            SQUASH:  if (!imem_stall)             state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output decode: priority-ordered hazard resolution, then SQUASH overrides.
    always_comb begin
        load_pc       = 1'b1;
        load_if_id    = 1'b1;
        load_id_ex    = 1'b1;
        load_ex_mem   = 1'b1;
        load_mem_wb   = 1'b1;
        bubble_if_id  = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_ex_mem = 1'b0;
        squash_fetch  = 1'b0;

        if (dmem_stall) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (md_busy) begin
            load_pc       = 1'b0;
            load_if_id    = 1'b0;
            load_id_ex    = 1'b0;
            bubble_ex_mem = 1'b1;
        end else if (ex_br_taken) begin
            bubble_if_id = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (lu) begin
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            bubble_id_ex = 1'b1;
        end else if (imem_stall) begin
            load_pc      = 1'b0;
            bubble_if_id = 1'b1;
        end

        // The in-flight fetch belongs to the old PC: never let it into
        // IF/ID, and keep the PC on the target unless a newer redirect lands.
        if (state_q == SQUASH) begin
            bubble_if_id = 1'b1;
            if (!br_accept) begin
                load_pc = 1'b0;
            end
            if (!imem_stall) begin
                squash_fetch = 1'b1;
            end
        end

        if (!rst) begin
            load_pc       = 1'b0;
            load_if_id    = 1'b0;
            load_id_ex    = 1'b0;
            load_ex_mem   = 1'b0;
            load_mem_wb   = 1'b0;
            bubble_if_id  = 1'b0;
            bubble_id_ex  = 1'b0;
            bubble_ex_mem = 1'b0;
            squash_fetch  = 1'b0;
        end
    end

    // A lost issue slot is any cycle where ID/EX does not take a real instruction.
    assign stall_inc = rst && (!load_id_ex || bubble_id_ex);
    assign flush_inc = rst && br_accept;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Two instances share the
//                stimulus: a 32-bit-counter unit and a 4-bit-counter unit
//                used to observe saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       imem_stall = 1'b0;
    logic       dmem_stall = 1'b0;
    logic       md_busy = 1'b0;
    logic       ex_br_taken = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [4:0] ex_rd = 5'd0;
    logic [4:0] id_rs1 = 5'd0;
    logic [4:0] id_rs2 = 5'd0;
    logic       id_rs1_used = 1'b0;
    logic       id_rs2_used = 1'b0;

    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        bubble_if_id, bubble_id_ex, bubble_ex_mem, squash_fetch;
    logic [31:0] stall_cnt, flush_cnt;

    logic        w4_load_pc, w4_load_if_id, w4_load_id_ex, w4_load_ex_mem, w4_load_mem_wb;
    logic        w4_bubble_if_id, w4_bubble_id_ex, w4_bubble_ex_mem, w4_squash_fetch;
    logic [3:0]  w4_stall_cnt, w4_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .md_busy(md_busy),
        .ex_br_taken(ex_br_taken), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .bubble_if_id(bubble_if_id), .bubble_id_ex(bubble_id_ex),
        .bubble_ex_mem(bubble_ex_mem), .squash_fetch(squash_fetch),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) u_dut_w4 (
        .clk(clk), .rst(rst),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .md_busy(md_busy),
        .ex_br_taken(ex_br_taken), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .load_pc(w4_load_pc), .load_if_id(w4_load_if_id), .load_id_ex(w4_load_id_ex),
        .load_ex_mem(w4_load_ex_mem), .load_mem_wb(w4_load_mem_wb),
        .bubble_if_id(w4_bubble_if_id), .bubble_id_ex(w4_bubble_id_ex),
        .bubble_ex_mem(w4_bubble_ex_mem), .squash_fetch(w4_squash_fetch),
        .stall_cnt(w4_stall_cnt), .flush_cnt(w4_flush_cnt)
    );

    // Expected-result record, one per applied cycle.
    typedef struct {
        string       tag;
        logic [8:0]  ctl;   // {ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb, b_ifid, b_idex, b_exmem, squash}
        logic [31:0] sc;
        logic [31:0] fc;
        logic [3:0]  sc4;
        logic [3:0]  fc4;
    } exp_t;

    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference-model state.
    bit          m_squash = 1'b0;
    logic [31:0] m_sc = '0;
    logic [31:0] m_fc = '0;
    int          m_sc4 = 0;
    int          m_fc4 = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, predict, then compare against the DUTs.
    task automatic step(input string tag, input bit r, input bit im, input bit dm,
                        input bit md, input bit br, input bit mr, input logic [4:0] rd,
                        input logic [4:0] s1, input logic [4:0] s2, input bit u1, input bit u2);
        exp_t e;
        bit   lu, br_ok, hold, lpc, lif, lidex, lexm, lmw, bif, bidex, bexm, sq, nxt;
        logic [8:0] obs;
        @(negedge clk);
        rst = r; imem_stall = im; dmem_stall = dm; md_busy = md; ex_br_taken = br;
        ex_mem_read = mr; ex_rd = rd; id_rs1 = s1; id_rs2 = s2;
        id_rs1_used = u1; id_rs2_used = u2;

        if (!r) begin
            m_squash = 1'b0; m_sc = '0; m_fc = '0; m_sc4 = 0; m_fc4 = 0;
        end
        lu    = mr && (rd != 5'd0) && ((u1 && s1 == rd) || (u2 && s2 == rd));
        hold  = dm || md;
        br_ok = br && !hold;
        if (hold)          lpc = 1'b0;
        else if (br)       lpc = 1'b1;
        else if (m_squash) lpc = 1'b0;
        else               lpc = !(lu || im);
        lif   = !hold && !(lu && !br);
        lidex = !hold;
        lexm  = !dm;
        lmw   = !dm;
        bif   = m_squash || (!hold && (br || (!lu && im)));
        bidex = !hold && (br || lu);
        bexm  = !dm && md;
        sq    = m_squash && !im;
        nxt   = m_squash ? im : (br_ok && im);

        e.tag = tag;
        e.ctl = r ? {lpc, lif, lidex, lexm, lmw, bif, bidex, bexm, sq} : 9'd0;
        e.sc  = m_sc;
        e.fc  = m_fc;
        e.sc4 = 4'(m_sc4);
        e.fc4 = 4'(m_fc4);
        sb_q.push_back(e);

        #2;
        if (sb_q.size() == 0) begin
            chk_val({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            obs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                   bubble_if_id, bubble_id_ex, bubble_ex_mem, squash_fetch};
            chk_val({e.tag, ".ctl"},   {23'd0, obs}, {23'd0, e.ctl});
            chk_val({e.tag, ".stall"}, stall_cnt,    e.sc);
            chk_val({e.tag, ".flush"}, flush_cnt,    e.fc);
            chk_val({e.tag, ".stall4"}, {28'd0, w4_stall_cnt}, {28'd0, e.sc4});
            chk_val({e.tag, ".flush4"}, {28'd0, w4_flush_cnt}, {28'd0, e.fc4});
        end

        // Registered effects at the coming clock edge.
        if (r) begin
            if (!lidex || bidex) begin
                if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
                if (m_sc4 < 15) m_sc4++;
            end
            if (br_ok) begin
                if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
                if (m_fc4 < 15) m_fc4++;
            end
            m_squash = nxt;
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // Reset state and release.
        step("rst_hold", 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle("idle0");
        idle("idle1");

        // Load-use on rs1, then x0 destination, rs2 use, and lu over imem_stall.
        step("lu_rs1",   1, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        step("lu_x0",    1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        step("lu_rs2",   1, 0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1);
        step("lu_unused",1, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd7, 0, 0);
        step("lu_imem",  1, 1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
        step("imem",     1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // Redirect while a fetch is outstanding, then the stale fetch returns.
        step("br_imem",  1, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("sq_wait1", 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("sq_wait2", 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("sq_drop",  1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle("post_sq");

        // Data-memory freeze defers the redirect.
        step("dm_br0",   1, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("dm_br1",   1, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("br_go",    1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // Mul/div busy, including an ignored branch.
        step("md0",      1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("md1",      1, 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("md2",      1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("md3",      1, 0, 0, 1, 0, 1, 5'd2, 5'd2, 5'd0, 1, 0);
        idle("post_md");

        // Reset asserted while in SQUASH.
        step("br_imem2", 1, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("sq_rst",   0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle("rst_rel");

        // Twenty load-use cycles: 4-bit counter must stick at 15.
        for (int i = 0; i < 20; i++) begin
            step("lu_sat", 1, 0, 0, 0, 0, 1, 5'd9, 5'd0, 5'd9, 0, 1);
        end
        idle("sat_end");

        // Random traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            step("rand", 1,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
